// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 SPI write-link receiver: opcodes,
// decoder states, default panel geometry and cursor/address widths.
package ili9341_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEFAULT_COLS = 240;
    localparam int DEFAULT_ROWS = 320;
    localparam int ADDR_W       = 17;
    localparam int CURSOR_W     = 9;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR,
        IGNORE
    } state_t;

    // True for the three opcodes the decoder acts on.
    function automatic logic is_known_cmd(input logic [7:0] i_byte);
        return (i_byte == CMD_CASET) || (i_byte == CMD_PASET) || (i_byte == CMD_RAMWR);
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte deserialiser: synchronises the panel-bus pins into the
// system clock domain, detects SCK rising edges and assembles MSB-first bytes.
// A high chip select throws away any partially received byte.
module spi_byte_rx
    import ili9341_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs_n,
    input  logic       i_sck,
    input  logic       i_mosi,
    input  logic       i_dc,
    output logic       o_byte_done,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_dc
);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic                   r_sck_prev;
    logic [6:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_byte_done;
    logic [7:0]             r_rx_byte;
    logic                   r_rx_dc;

    logic w_cs_n;
    logic w_sck;
    logic w_mosi;
    logic w_dc;
    logic w_sck_rise;

    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_dc       = r_dc_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;

    // Synchroniser chains; chip select resets to the deselected level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], i_dc};
        end
    end

    // Shift in one bit per SCK rise; the eighth bit emits the byte and its D/C flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck_prev  <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_rx_byte   <= '0;
            r_rx_dc     <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_sck_prev  <= w_sck;
            if (w_cs_n) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_done <= 1'b1;
                    r_rx_byte   <= {r_shift, w_mosi};
                    r_rx_dc     <= w_dc;
                end
            end
        end
    end

    assign o_byte_done = r_byte_done;
    assign o_rx_byte   = r_rx_byte;
    assign o_rx_dc     = r_rx_dc;

endmodule

// File: rtl/ili9341_spi_receiver.sv
// Display-side ILI9341 write-link emulator: decodes CASET/PASET/RAMWR from the
// byte stream and turns RAMWR data into 16-bit framebuffer writes addressed by
// a column/page cursor that wraps inside the programmed windows.
module ili9341_spi_receiver
    import ili9341_pkg::*;
#(
    parameter int COLS        = DEFAULT_COLS,
    parameter int ROWS        = DEFAULT_ROWS,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              spiCs,
    input  logic              spiSck,
    input  logic              spiMosi,
    input  logic              spiDc,
    output logic              pixWrEn,
    output logic [ADDR_W-1:0] pixAddr,
    output logic [15:0]       pixData,
    output logic              cmdStrobe,
    output logic [7:0]        cmdByte,
    output logic              unknownCmd
);

    localparam logic [CURSOR_W-1:0] EC_RESET  = CURSOR_W'(COLS - 1);
    localparam logic [CURSOR_W-1:0] EP_RESET  = CURSOR_W'(ROWS - 1);
    localparam logic [CURSOR_W:0]   COLS_LIM  = (CURSOR_W + 1)'(COLS);
    localparam logic [CURSOR_W:0]   ROWS_LIM  = (CURSOR_W + 1)'(ROWS);

    logic       w_byte_done;
    logic [7:0] w_rx_byte;
    logic       w_rx_dc;

    state_t r_state;
    state_t w_state_next;

    // Only bits [8:0] of the window bounds influence the cursor, so the upper
    // parameter bits are not kept.
    logic [CURSOR_W-1:0] r_sc;
    logic [CURSOR_W-1:0] r_ec;
    logic [CURSOR_W-1:0] r_sp;
    logic [CURSOR_W-1:0] r_ep;
    logic [CURSOR_W-1:0] r_col;
    logic [CURSOR_W-1:0] r_row;
    logic [1:0]          r_param_idx;
    logic                r_half;
    logic [7:0]          r_pix_hi;

    logic              r_pix_wr;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [15:0]       r_pix_data;
    logic              r_cmd_strobe;
    logic [7:0]        r_cmd_byte;
    logic              r_unknown;

    logic [ADDR_W-1:0] w_addr;
    logic              w_in_range;
    logic              w_cmd_done;
    logic              w_data_done;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .i_clk       (CLK_I),
        .i_rst       (RST_I),
        .i_cs_n      (spiCs),
        .i_sck       (spiSck),
        .i_mosi      (spiMosi),
        .i_dc        (spiDc),
        .o_byte_done (w_byte_done),
        .o_rx_byte   (w_rx_byte),
        .o_rx_dc     (w_rx_dc)
    );

    assign w_cmd_done  = w_byte_done & ~w_rx_dc;
    assign w_data_done = w_byte_done & w_rx_dc;

    // Row-major framebuffer address; the product is truncated to the port width.
    assign w_addr     = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
    assign w_in_range = ({1'b0, r_col} < COLS_LIM) && ({1'b0, r_row} < ROWS_LIM);

    // Decoder state register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: commands select the mode, the fourth window parameter returns to IDLE.
    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        if (w_cmd_done) begin
            case (w_rx_byte)
                CMD_CASET: w_state_next = CASET;
                CMD_PASET: w_state_next = PASET;
                CMD_RAMWR: w_state_next = RAMWR;
                default:   w_state_next = IGNORE;
            endcase
        end else if (w_data_done) begin
            if ((r_state == CASET || r_state == PASET) && r_param_idx == 2'd3) begin
                w_state_next = IDLE;
            end
        end
    end

    // Command bookkeeping, window loading, pixel assembly and cursor movement.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_sc         <= '0;
            r_ec         <= EC_RESET;
            r_sp         <= '0;
            r_ep         <= EP_RESET;
            r_col        <= '0;
            r_row        <= '0;
            r_param_idx  <= '0;
            r_half       <= 1'b0;
            r_pix_hi     <= '0;
            r_pix_wr     <= 1'b0;
            r_pix_addr   <= '0;
            r_pix_data   <= '0;
            r_cmd_strobe <= 1'b0;
            r_cmd_byte   <= '0;
            r_unknown    <= 1'b0;
        end else begin
            r_cmd_strobe <= 1'b0;
            r_pix_wr     <= 1'b0;
            if (w_cmd_done) begin
                r_cmd_strobe <= 1'b1;
                r_cmd_byte   <= w_rx_byte;
                r_param_idx  <= '0;
                r_half       <= 1'b0;
                r_unknown    <= ~is_known_cmd(w_rx_byte);
                if (w_rx_byte == CMD_RAMWR) begin
                    r_col <= r_sc;
                    r_row <= r_sp;
                end
            end else if (w_data_done) begin
                case (r_state)
                    CASET: begin
                        case (r_param_idx)
                            2'd0:    r_sc[8]   <= w_rx_byte[0];
                            2'd1:    r_sc[7:0] <= w_rx_byte;
                            2'd2:    r_ec[8]   <= w_rx_byte[0];
                            default: r_ec[7:0] <= w_rx_byte;
                        endcase
                        r_param_idx <= r_param_idx + 2'd1;
                    end
                    PASET: begin
                        case (r_param_idx)
                            2'd0:    r_sp[8]   <= w_rx_byte[0];
                            2'd1:    r_sp[7:0] <= w_rx_byte;
                            2'd2:    r_ep[8]   <= w_rx_byte[0];
                            default: r_ep[7:0] <= w_rx_byte;
                        endcase
                        r_param_idx <= r_param_idx + 2'd1;
                    end
                    RAMWR: begin
                        if (!r_half) begin
                            r_pix_hi <= w_rx_byte;
                            r_half   <= 1'b1;
                        end else begin
                            r_half     <= 1'b0;
                            r_pix_data <= {r_pix_hi, w_rx_byte};
                            r_pix_addr <= w_addr;
                            r_pix_wr   <= w_in_range;
                            // Equality-only wrap: a cursor past the window end runs to 511 and rolls to 0.
                            if (r_col == r_ec) begin
                                r_col <= r_sc;
                                if (r_row == r_ep) begin
                                    r_row <= r_sp;
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign pixWrEn    = r_pix_wr;
    assign pixAddr    = r_pix_addr;
    assign pixData    = r_pix_data;
    assign cmdStrobe  = r_cmd_strobe;
    assign cmdByte    = r_cmd_byte;
    assign unknownCmd = r_unknown;

endmodule
